uart_tx: RTL and testbench

- UART transmit serializer for the peripheral UART.
- Pops bytes from the TX FIFO and shifts each out on the txd line as a frame: start, data bits LSB first, stop bit(s).
- Bit timing comes from a programmable clock divider.
- Sits directly downstream of the TX FIFO. Its outputs are the UART pin and status for the register block.

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit serializer: pops one character from the TX FIFO and sends start, data (LSB first), optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DIV_SIZE  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 nstop,
  input  logic [DIV_SIZE-1:0]  div,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [DIV_SIZE-1:0]  baud_q, baud_d;
  logic [DIV_SIZE-1:0]  div_lat_q, div_lat_d;
  logic                 nstop_lat_q, nstop_lat_d;
  logic                 stop2_q, stop2_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic pop;
  logic tick;

  // Pop is suppressed while reset is held so no character is lost into a flop being cleared.
  assign pop  = reset && (state_q == ST_IDLE) && tx_en && !fifo_empty;
  assign tick = (baud_q == div_lat_q);

  assign fifo_rd_en = pop;
  assign txd        = txd_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    div_lat_d   = div_lat_q;
    nstop_lat_d = nstop_lat_q;
    stop2_d     = stop2_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (state_q != ST_IDLE) begin
      baud_d = tick ? '0 : baud_q + DIV_SIZE'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d     = fifo_rd_data;
          div_lat_d   = div;
          nstop_lat_d = nstop;
          baud_d      = '0;
          bit_d       = '0;
          stop2_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^fifo_rd_data;
`endif
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (nstop_lat_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the next state so each level lines up with the state it belongs to.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      div_lat_q   <= '0;
      nstop_lat_q <= 1'b0;
      stop2_q     <= 1'b0;
      bit_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      div_lat_q   <= div_lat_d;
      nstop_lat_q <= nstop_lat_d;
      stop2_q     <= stop2_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected serial frames are built from the character, divisor and stop setting.
module tb_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tx_en = 1'b0;
  logic        nstop = 1'b0;
  logic [15:0] div   = '0;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        txd;
  logic        busy;

  logic [7:0]  fifo_mem [8];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pop_cnt = 0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  uart_tx #(.DATA_SIZE(8), .DIV_SIZE(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_en        (tx_en),
    .nstop        (nstop),
    .div          (div),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .txd          (txd),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = fifo_mem[rd_ptr[2:0]];

  always @(posedge clock) begin
    if (fifo_rd_en && !fifo_empty) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr[2:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_busy();
    int unsigned n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("busy_rise", busy, 1'b1);
  endtask

  // Assumes the current negedge is the first start-bit cycle; leaves off at the cycle after the last stop bit.
  task automatic check_frame(input logic [7:0] data, input int unsigned dv, input logic ns,
                             input int unsigned mod_at);
    logic        bits [13];
    int unsigned n = 0;
    int unsigned cyc = 0;
    bits[n] = 1'b0; n++;
    for (int unsigned i = 0; i < 8; i++) begin
      bits[n] = data[i]; n++;
    end
`ifdef UART_TX_PARITY_EN
    bits[n] = ^data; n++;
`endif
    bits[n] = 1'b1; n++;
    if (ns) begin
      bits[n] = 1'b1; n++;
    end
    for (int unsigned b = 0; b < n; b++) begin
      for (int unsigned c = 0; c <= dv; c++) begin
        check("frame_txd", txd, bits[b]);
        check("frame_busy", busy, 1'b1);
        cyc++;
        if (mod_at != 0 && cyc == mod_at) begin
          tx_en = 1'b0;
          div   = 16'd7;
          nstop = 1'b1;
        end
        @(negedge clock);
      end
    end
  endtask

  initial begin
    // Reset with empty FIFO and enable high
    tx_en = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 100; i++) begin
      check("idle_rd_en", fifo_rd_en, 1'b0);
      @(negedge clock);
    end
    check("idle_txd", txd, 1'b1);
    check("idle_pops", pop_cnt, 0);

    // 0x55, div=3, one stop bit
    div = 16'd3; nstop = 1'b0;
    push(8'h55);
    #1 check("pop_strobe", fifo_rd_en, 1'b1);
    @(negedge clock);
    wait_busy();
    check_frame(8'h55, 3, 1'b0, 0);
    check("f55_end_busy", busy, 1'b0);
    check("f55_end_txd", txd, 1'b1);
    check("f55_pops", pop_cnt, 1);

    // Back-to-back 0xA3, 0x0F at div=0 with two stop bits
    div = 16'd0; nstop = 1'b1;
    push(8'hA3);
    push(8'h0F);
    #1 check("b2b_strobe", fifo_rd_en, 1'b1);
    @(negedge clock);
    wait_busy();
    check_frame(8'hA3, 0, 1'b1, 0);
    check("gap_busy", busy, 1'b0);
    check("gap_txd", txd, 1'b1);
    check("gap_rd_en", fifo_rd_en, 1'b1);
    @(negedge clock);
    check_frame(8'h0F, 0, 1'b1, 0);
    check("b2b_end_busy", busy, 1'b0);
    check("b2b_pops", pop_cnt, 3);

    // 0xFF at div=2; tx_en dropped and div/nstop changed during data bit 3
    div = 16'd2; nstop = 1'b0;
    push(8'hFF);
    push(8'h00);
    @(negedge clock);
    wait_busy();
    check_frame(8'hFF, 2, 1'b0, 13);
    check("mod_end_busy", busy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("mod_no_pop", fifo_rd_en, 1'b0);
      @(negedge clock);
    end
    check("mod_pops", pop_cnt, 4);
    check("mod_idle_busy", busy, 1'b0);

    // Reset during DATA of 0x00, then 0x5A from a clean start
    div = 16'd1; nstop = 1'b0;
    push(8'h5A);
    tx_en = 1'b1;
    @(negedge clock);
    wait_busy();
    repeat (6) @(negedge clock);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_txd", txd, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    reset = 1'b1;
    #1 check("post_rst_strobe", fifo_rd_en, 1'b1);
    @(negedge clock);
    check_frame(8'h5A, 1, 1'b0, 0);
    check("post_rst_end_busy", busy, 1'b0);
    check("post_rst_pops", pop_cnt, 6);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 gives 1, 0x03 gives 0
    tx_en = 1'b0;
    push(8'h07);
    tx_en = 1'b1;
    @(negedge clock);
    wait_busy();
    check_frame(8'h07, 1, 1'b0, 0);
    check("par07_end_busy", busy, 1'b0);
    push(8'h03);
    @(negedge clock);
    wait_busy();
    check_frame(8'h03, 1, 1'b0, 0);
    check("par03_end_busy", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
